multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 139 +++++++++++++
 tb/tb_multicycle_control.sv | 133 +++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-style control FSM with an opcode hold register and a sticky illegal-opcode flag
module multicycle_control #(
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);
  typedef enum logic [3:0] {
    S_IF = 4'd0, S_ID = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_RD = 4'd3,
    S_MEM_WB = 4'd4, S_MEM_WR = 4'd5, S_R_EX = 4'd6, S_R_WB = 4'd7,
    S_BR = 4'd8, S_JMP = 4'd9, S_I_EX = 4'd10, S_I_WB = 4'd11
  } state_t;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
  state_t cur, nxt;
  logic [5:0] op_q;
  logic legal;
  assign legal = opcode == OP_R || opcode == OP_LW || opcode == OP_SW ||
                 opcode == OP_BEQ || opcode == OP_J || opcode == OP_ADDI;
  assign state = cur;
  always_comb begin
    nxt = S_IF;
    case (cur)
      S_IF:       nxt = mem_ready ? S_ID : S_IF;
      S_ID:       nxt = opcode == OP_R ? S_R_EX :
                        (opcode == OP_LW || opcode == OP_SW) ? S_MEM_ADDR :
                        opcode == OP_BEQ ? S_BR :
                        opcode == OP_J ? S_JMP :
                        opcode == OP_ADDI ? S_I_EX : S_IF;
      S_MEM_ADDR: nxt = op_q == OP_LW ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
      S_MEM_WR:   nxt = mem_ready ? S_IF : S_MEM_WR;
      S_R_EX:     nxt = S_R_WB;
      S_I_EX:     nxt = S_I_WB;
      default:    nxt = S_IF;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur     <= S_IF;
      op_q    <= '0;
      illegal <= 1'b0;
    end else begin
      cur <= nxt;
      if (cur == S_ID) op_q <= opcode;
      if (cur == S_ID && !legal && ILLEGAL_TRAP != 0) illegal <= 1'b1;
    end
  end
  // rst gates the decode so nothing strobes while reset is held, even in IF
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_to_reg    = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    instr_done    = 1'b0;
    if (!rst) begin
      case (cur)
        S_IF: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          pc_write  = mem_ready;
          ir_write  = mem_ready;
        end
        S_ID: alu_src_b = 2'b11;
        S_MEM_ADDR, S_I_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        S_MEM_RD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WR: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          instr_done = mem_ready;
        end
        S_R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = 2'b10;
        end
        S_R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          instr_done = 1'b1;
        end
        S_BR: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'b01;
          pc_write_cond = 1'b1;
          pc_source     = 2'b01;
          instr_done    = 1'b1;
        end
        S_JMP: begin
          pc_write   = 1'b1;
          pc_source  = 2'b10;
          instr_done = 1'b1;
        end
        S_I_WB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven check of the multicycle control FSM, plus reset and no-trap corner cases
module tb_multicycle_control;
  logic clk = 1'b0, rst = 1'b1, mem_ready = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, done, ill;
  logic [1:0] asb, aop, psrc;
  logic [3:0] st;
  logic pcw2, pcwc2, iord2, mrd2, mwr2, m2r2, irw2, rdst2, rw2, asa2, done2, ill2;
  logic [1:0] asb2, aop2, psrc2;
  logic [3:0] st2;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  multicycle_control #(.ILLEGAL_TRAP(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw), .pc_write_cond(pcwc), .i_or_d(iord), .mem_read(mrd), .mem_write(mwr),
    .mem_to_reg(m2r), .ir_write(irw), .reg_dst(rdst), .reg_write(rw), .alu_src_a(asa),
    .alu_src_b(asb), .alu_op(aop), .pc_source(psrc), .state(st), .instr_done(done), .illegal(ill));
  multicycle_control #(.ILLEGAL_TRAP(0)) dut_nt (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pcw2), .pc_write_cond(pcwc2), .i_or_d(iord2), .mem_read(mrd2), .mem_write(mwr2),
    .mem_to_reg(m2r2), .ir_write(irw2), .reg_dst(rdst2), .reg_write(rw2), .alu_src_a(asa2),
    .alu_src_b(asb2), .alu_op(aop2), .pc_source(psrc2), .state(st2), .instr_done(done2), .illegal(ill2));
  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic [3:0] st;
    logic [9:0] ctl;
    logic [1:0] b, aop, src;
    logic       done, ill;
  } vec_t;
  vec_t v[$];
  // strobe order: pc_write pc_write_cond i_or_d mem_read mem_write mem_to_reg ir_write reg_dst reg_write alu_src_a
  localparam logic [9:0] C_IF1 = 10'b1001001000, C_IF0 = 10'b0001000000, C_ID = 10'b0000000000;
  localparam logic [9:0] C_EX = 10'b0000000001, C_RD = 10'b0011000000, C_WB = 10'b0000010010;
  localparam logic [9:0] C_WR = 10'b0010100000, C_RWB = 10'b0000000110, C_BR = 10'b0100000001;
  localparam logic [9:0] C_J = 10'b1000000000, C_IWB = 10'b0000000010;
  function automatic logic [21:0] act();
    return {st, pcw, pcwc, iord, mrd, mwr, m2r, irw, rdst, rw, asa, asb, aop, psrc, done, ill};
  endfunction
  task automatic check(input string nm, input logic [21:0] a, input logic [21:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, a, e);
    end
  endtask
  task automatic add(input logic [5:0] op, input logic rdy, input logic [3:0] s, input logic [9:0] c,
                     input logic [1:0] b, input logic [1:0] ao, input logic [1:0] src,
                     input logic dn, input logic il);
    v.push_back('{op, rdy, s, c, b, ao, src, dn, il});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    // R-type
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 6, C_EX,  2'b00, 2'b10, 2'b00, 0, 0);
    add(6'h00, 1, 7, C_RWB, 2'b00, 2'b00, 2'b00, 1, 0);
    // lw with three wait cycles; opcode changes to sw in MEM_ADDR to prove the held copy is used
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h23, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 0);
    add(6'h2B, 1, 2, C_EX,  2'b10, 2'b00, 2'b00, 0, 0);
    add(6'h00, 0, 3, C_RD,  2'b00, 2'b00, 2'b00, 0, 0);
    add(6'h00, 0, 3, C_RD,  2'b00, 2'b00, 2'b00, 0, 0);
    add(6'h00, 0, 3, C_RD,  2'b00, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 3, C_RD,  2'b00, 2'b00, 2'b00, 0, 0);
    add(6'h00, 0, 4, C_WB,  2'b00, 2'b00, 2'b00, 1, 0);
    // sw with one IF wait and one MEM_WR wait
    add(6'h00, 0, 0, C_IF0, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h2B, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 0);
    add(6'h23, 1, 2, C_EX,  2'b10, 2'b00, 2'b00, 0, 0);
    add(6'h00, 0, 5, C_WR,  2'b00, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 5, C_WR,  2'b00, 2'b00, 2'b00, 1, 0);
    // beq, j, addi
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h04, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 0);
    add(6'h00, 0, 8, C_BR,  2'b00, 2'b01, 2'b01, 1, 0);
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h02, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 0);
    add(6'h00, 0, 9, C_J,   2'b00, 2'b00, 2'b10, 1, 0);
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h08, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 10, C_EX, 2'b10, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 11, C_IWB, 2'b00, 2'b00, 2'b00, 1, 0);
    // illegal opcode, then addi with illegal held
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 0);
    add(6'h3F, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 0);
    add(6'h00, 1, 0, C_IF1, 2'b01, 2'b00, 2'b00, 0, 1);
    add(6'h08, 1, 1, C_ID,  2'b11, 2'b00, 2'b00, 0, 1);
    add(6'h00, 1, 10, C_EX, 2'b10, 2'b00, 2'b00, 0, 1);
    add(6'h00, 1, 11, C_IWB, 2'b00, 2'b00, 2'b00, 1, 1);
    @(negedge clk);
    @(negedge clk);
    #1 check("reset_hold", act(), 22'b0);
    check("reset_hold_nt", {21'b0, ill2}, 22'b0);
    @(negedge clk);
    rst = 1'b0;
    foreach (v[i]) begin
      opcode = v[i].op;
      mem_ready = v[i].rdy;
      #1 check($sformatf("row%0d", i), act(),
               {v[i].st, v[i].ctl, v[i].b, v[i].aop, v[i].src, v[i].done, v[i].ill});
      check($sformatf("row%0d_nt_illegal", i), {21'b0, ill2}, 22'b0);
      @(negedge clk);
    end
    // sw stalled in MEM_WR, then asynchronous reset mid-cycle
    opcode = 6'h00; mem_ready = 1'b1;
    #1 check("sw2_if", {act()[21:18], 18'b0}, {4'd0, 18'b0});
    @(negedge clk);
    opcode = 6'h2B;
    #1 check("sw2_id", {act()[21:18], 18'b0}, {4'd1, 18'b0});
    @(negedge clk);
    opcode = 6'h00;
    #1 check("sw2_addr", {act()[21:18], 18'b0}, {4'd2, 18'b0});
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("sw2_wr_wait", act(), {4'd5, C_WR, 6'b0, 1'b0, 1'b1});
    #2 rst = 1'b1;
    #1 check("async_reset_in_wr", act(), 22'b0);
    @(posedge clk);
    #1 check("reset_over_edge", act(), 22'b0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("after_release", act(), {4'd0, C_IF0, 2'b01, 4'b0, 1'b0, 1'b0});
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
